// File: rtl/fp_mul_seq_pkg.sv
// Shared definitions for the sequential single-precision multiplier:
// class codes, quiet-NaN pattern, exponent bias and FSM state encoding.
package fp_pkg;

  localparam logic [2:0] CLS_ZERO   = 3'b000;
  localparam logic [2:0] CLS_NAN    = 3'b110;
  localparam logic [2:0] CLS_INF    = 3'b100;
  localparam logic [2:0] CLS_NORMAL = 3'b011;

  localparam logic [31:0]       QNAN = 32'h7FC0_0000;
  localparam logic signed [9:0] BIAS = 10'sd127;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLASS,
    S_MUL,
    S_NORM,
    S_DONE
  } state_e;

endpackage

// File: rtl/fp_mul_seq_if.sv
// Operand/result handshake bundle for fp_mul_seq.
// The producer/consumer side uses master; the multiplier uses slave.
interface fp_mul_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;
  logic [2:0]  out_class;
  logic        busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, result, out_class, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, result, out_class, busy
  );
endinterface

// File: rtl/fp_mul_seq_classify.sv
// Combinational single-precision class decode; zero latency, no handshake.
// Denormals are reported as NaN because the datapath does not handle them.
module fp_classify
  import fp_pkg::*;
(
  input  logic [31:0] val,
  output logic [2:0]  cls
);

  logic [7:0]  exp_f;
  logic [22:0] mant_f;
  logic        unused_sign;

  assign exp_f       = val[30:23];
  assign mant_f      = val[22:0];
  assign unused_sign = val[31];

  always_comb begin
    cls = CLS_NORMAL;
    if (exp_f == 8'h00) begin
      cls = (mant_f == 23'd0) ? CLS_ZERO : CLS_NAN;
    end else if (exp_f == 8'hFF) begin
      cls = (mant_f == 23'd0) ? CLS_INF : CLS_NAN;
    end
  end

endmodule

// File: rtl/fp_mul_seq.sv
// Sequential FP32 multiply: specials resolve 1 edge after accept, normals 26 edges (24-step shift-add).
// One operation in flight; result and class hold in DONE until out_ready, inputs ignored while busy.
module fp_mul_seq
  import fp_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  fp_mul_seq_if.slave  bus
);

  state_e             state_q, state_d;
  logic [31:0]        a_q, a_d, b_q, b_d;
  logic [31:0]        result_q, result_d;
  logic               sign_q, sign_d;
  logic signed [9:0]  exp_q, exp_d, exp_n;
  logic [47:0]        acc_q, acc_d;
  logic [23:0]        mcand_q, mcand_d, mplier_q, mplier_d;
  logic [4:0]         cnt_q, cnt_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic               busy_q, busy_d;
  logic [2:0]         cls_a, cls_b, cls_r;
  logic [22:0]        mant_n;
  logic               unused_acc_lo;

  fp_classify u_cls_a (.val(a_q),      .cls(cls_a));
  fp_classify u_cls_b (.val(b_q),      .cls(cls_b));
  fp_classify u_cls_r (.val(result_q), .cls(cls_r));

  // Product of two 1.x mantissas lies in [1,4): bit 47 set means one extra exponent step.
  assign exp_n         = exp_q + $signed({9'd0, acc_q[47]});
  assign mant_n        = acc_q[47] ? acc_q[46:24] : acc_q[45:23];
  assign unused_acc_lo = ^acc_q[22:0];

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    result_d    = result_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    acc_d       = acc_q;
    mcand_d     = mcand_q;
    mplier_d    = mplier_q;
    cnt_d       = cnt_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;

    case (state_q)
      S_IDLE: begin
        if (bus.in_valid && in_ready_q) begin
          a_d        = bus.a;
          b_d        = bus.b;
          state_d    = S_CLASS;
          in_ready_d = 1'b0;
          busy_d     = 1'b1;
        end
      end

      S_CLASS: begin
        sign_d = a_q[31] ^ b_q[31];
        if ((cls_a == CLS_NAN) || (cls_b == CLS_NAN) ||
            ((cls_a == CLS_INF) && (cls_b == CLS_ZERO)) ||
            ((cls_a == CLS_ZERO) && (cls_b == CLS_INF))) begin
          result_d    = QNAN;
          state_d     = S_DONE;
          out_valid_d = 1'b1;
        end else if ((cls_a == CLS_INF) || (cls_b == CLS_INF)) begin
          result_d    = {sign_d, 8'hFF, 23'd0};
          state_d     = S_DONE;
          out_valid_d = 1'b1;
        end else if ((cls_a == CLS_ZERO) || (cls_b == CLS_ZERO)) begin
          result_d    = {sign_d, 31'd0};
          state_d     = S_DONE;
          out_valid_d = 1'b1;
        end else begin
          exp_d    = $signed({2'b00, a_q[30:23]}) + $signed({2'b00, b_q[30:23]}) - BIAS;
          acc_d    = 48'd0;
          mcand_d  = {1'b1, a_q[22:0]};
          mplier_d = {1'b1, b_q[22:0]};
          cnt_d    = 5'd0;
          state_d  = S_MUL;
        end
      end

      S_MUL: begin
        acc_d    = acc_q + (mplier_q[0] ? ({24'd0, mcand_q} << cnt_q) : 48'd0);
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 5'd1;
        if (cnt_q == 5'd23) begin
          state_d = S_NORM;
        end
      end

      S_NORM: begin
        exp_d = exp_n;
        if (exp_n >= 10'sd255) begin
          result_d = {sign_q, 8'hFF, 23'd0};
        end else if (exp_n <= 10'sd0) begin
          result_d = {sign_q, 31'd0};
        end else begin
          result_d = {sign_q, exp_n[7:0], mant_n};
        end
        state_d     = S_DONE;
        out_valid_d = 1'b1;
      end

      S_DONE: begin
        if (bus.out_ready) begin
          state_d     = S_IDLE;
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          busy_d      = 1'b0;
        end
      end

      default: begin
        state_d     = S_IDLE;
        out_valid_d = 1'b0;
        in_ready_d  = 1'b1;
        busy_d      = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      result_q    <= 32'd0;
      sign_q      <= 1'b0;
      exp_q       <= 10'sd0;
      acc_q       <= 48'd0;
      mcand_q     <= 24'd0;
      mplier_q    <= 24'd0;
      cnt_q       <= 5'd0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      result_q    <= result_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.result    = result_q;
  assign bus.out_class = cls_r;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_fp_mul_seq.sv
// Directed bench for fp_mul_seq: expected products queued at accept, popped when out_valid rises.
module tb_fp_mul_seq;

  typedef struct packed {
    logic [31:0] res;
    logic [2:0]  cls;
  } exp_t;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  exp_t sb[$];

  fp_mul_seq_if bus ();

  fp_mul_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the result handshake.
  task automatic do_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                       input logic [31:0] er, input logic [2:0] ec,
                       input int elat, input int hold);
    int   waited;
    int   lat;
    bit   got;
    exp_t e;
    bus.a        = av;
    bus.b        = bv;
    bus.in_valid = 1'b1;
    bus.out_ready = (hold == 0);
    sb.push_back('{res: er, cls: ec});
    waited = 0;
    while (!bus.in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.a        = $urandom;
    bus.b        = $urandom;
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 60 && !got; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.out_valid) got = 1'b1;
    end
    chk({tag, "_out_valid_seen"}, 32'(got), 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(elat));
    checks++;
    assert (sb.size() != 0)
    else begin
      errors++;
      $error("FAIL %s_scoreboard observed empty expected entry", tag);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_result"}, bus.result, e.res);
      chk({tag, "_class"}, 32'(bus.out_class), 32'(e.cls));
      chk({tag, "_no_in_ready"}, 32'(bus.in_ready), 32'd0);
      for (int i = 0; i < hold; i++) begin
        bus.in_valid = 1'b1;
        bus.a        = 32'h3F80_0000 + 32'(i);
        bus.b        = 32'h4000_0000;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
        chk({tag, "_hold_result"}, bus.result, e.res);
        chk({tag, "_hold_class"}, 32'(bus.out_class), 32'(e.cls));
        chk({tag, "_hold_in_ready"}, 32'(bus.in_ready), 32'd0);
      end
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk({tag, "_valid_drop"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_idle_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    checks        = 0;
    errors        = 0;
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.a         = 32'd0;
    bus.b         = 32'd0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_result", bus.result, 32'd0);
    chk("rst_class", 32'(bus.out_class), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    do_op("mul_2x3",     32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 3'b011, 26, 0);
    do_op("inf_x_zero",  32'h7F80_0000, 32'h0000_0000, 32'h7FC0_0000, 3'b110, 1, 0);
    do_op("denorm_nan",  32'h0000_0001, 32'h3F80_0000, 32'h7FC0_0000, 3'b110, 1, 0);
    do_op("neg_x_inf",   32'hBFC0_0000, 32'h7F80_0000, 32'hFF80_0000, 3'b100, 1, 0);
    do_op("negzero_x_1", 32'h8000_0000, 32'h3F80_0000, 32'h8000_0000, 3'b000, 1, 0);
    do_op("neg2_x_3",    32'hC000_0000, 32'h4040_0000, 32'hC0C0_0000, 3'b011, 26, 0);
    do_op("overflow",    32'h7F00_0000, 32'h7F00_0000, 32'h7F80_0000, 3'b100, 26, 0);
    do_op("underflow",   32'h0080_0000, 32'h0080_0000, 32'h0000_0000, 3'b000, 26, 0);
    do_op("backpress",   32'h3FC0_0000, 32'h4000_0000, 32'h4040_0000, 3'b011, 26, 5);
    do_op("after_bp",    32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 3'b011, 26, 0);

    // Abort an operation partway through the multiply loop.
    bus.a        = 32'h4000_0000;
    bus.b        = 32'h4040_0000;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("mid_mul_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
    chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_result", bus.result, 32'd0);
    chk("abort_class", 32'(bus.out_class), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    do_op("one_x_one",   32'h3F80_0000, 32'h3F80_0000, 32'h3F80_0000, 3'b011, 26, 0);

    chk("sb_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_mul_seq.md
# fp_mul_seq

Multi-cycle IEEE-754 single-precision multiply sequencer. It accepts an operand pair over a valid/ready handshake and classifies both operands with the team's class encoding. Special cases resolve immediately; normal operands go through a 24-step shift-add mantissa datapath. The block normalizes, truncates and returns the product with its class over a valid/ready output handshake, and sits between the operand source and any FP consumer that tolerates variable latency.

## Interface
- No parameters; width fixed at 32 (1 sign, 8 exponent, 23 mantissa, bias 127).
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept; high only in IDLE.
- a  input  32  operand A, sampled on accept.
- b  input  32  operand B, sampled on accept.
- out_valid  output  1  result valid; high only in DONE.
- out_ready  input  1  consumer accepts result.
- result  output  32  product.
- out_class  output  3  class of result: 000 Zero, 110 NaN, 100 Inf, 011 Normal.
- busy  output  1  high in every state except IDLE.

## Operation
- Class rules, per operand:
  - exp==0 and mant==0: Zero.
  - exp==0 and mant!=0: NaN. Denormals are not supported.
  - exp==255 and mant==0: Inf.
  - exp==255 and mant!=0: NaN.
  - Otherwise: Normal.
- States: IDLE, CLASS, MUL, NORM, DONE.
- IDLE: an accept occurs when in_valid && in_ready. On accept, latch a and b, then go to CLASS.
- CLASS: sign = a[31]^b[31].
  - Either operand NaN, or Inf×Zero: result 0x7FC00000, go to DONE.
  - Inf × (Inf or Normal): result {sign, 0xFF, 0}, go to DONE.
  - Zero × (Zero or Normal): result {sign, 31'b0}, go to DONE.
  - Normal × Normal: set exp = ea + eb − 127 as a 10-bit signed value. Set acc[47:0] = 0, mcand = {1, ma}, mplier = {1, mb}, cnt = 0. Go to MUL.
- MUL: each cycle, acc += mplier[0] ? (mcand << cnt) : 0. Then mplier >>= 1 and cnt++. After cnt reaches 23 (24 steps), go to NORM.
- NORM (one cycle):
  - If acc[47]: mant = acc[46:24], exp += 1.
  - Else: mant = acc[45:23].
  - Truncate; no rounding.
  - If exp ≥ 255: result {sign, 0xFF, 0}.
  - If exp ≤ 0: result {sign, 31'b0}, flush to zero.
  - Else: result {sign, exp[7:0], mant}.
  - Go to DONE.
- DONE: result and out_class are held stable while out_valid && !out_ready. On out_ready, go to IDLE.
- in_valid is ignored outside IDLE; a, b and in_valid may change freely while busy.
- out_class is computed from the registered result using the class rules above.

## Timing
- Reset (async, rst_n low): state IDLE, in_ready=1, out_valid=0, busy=0, result=0, out_class=000, all internal registers 0.
- Reset mid-operation aborts the operation with no output. The first accept after rst_n deasserts proceeds normally.
- Latency is measured from the accept edge E0:
  - Special case: DONE entered at E1; out_valid high in the cycle after E1.
  - Normal case: CLASS at E0→E1, MUL at E1–E24, NORM at E25, DONE entered at E26.
- Handshake:
  - out_ready may already be high when DONE is entered. In that case out_valid is high for exactly one cycle.
  - IDLE is re-entered on the next edge; in_ready rises then.
  - Minimum spacing between accepts is therefore result cycle + 1 idle cycle.
- Simultaneous events: none possible. in_ready and out_valid are never high together.

## Structure
- Shared package fp_pkg holds:
  - class codes CLS_ZERO/CLS_NAN/CLS_INF/CLS_NORMAL;
  - QNAN = 32'h7FC00000;
  - BIAS = 127;
  - the state enum.
- Sub-module fp_classify: 32-bit input to 3-bit class, combinational. It is instantiated three times: on latched A, latched B, and on result.
- Top-level: FSM, 5-bit cnt, 48-bit acc, 24-bit mcand/mplier, 10-bit signed exp, sign and result registers.

## Test plan
- 0x40000000 × 0x40400000 (2×3) -> result 0x40C00000, out_class 011; out_valid first high 26 edges after accept.
- 0x7F800000 × 0x00000000 -> 0x7FC00000, class 110, out_valid high the cycle after E1. Also 0x00000001 × 0x3F800000 -> 0x7FC00000, because a denormal is classed NaN.
- 0xBFC00000 × 0x7F800000 -> 0xFF800000, class 100. Also 0x80000000 × 0x3F800000 -> 0x80000000, class 000.
- Overflow: 0x7F000000 × 0x7F000000 -> 0x7F800000. Underflow: 0x00800000 × 0x00800000 -> 0x00000000, class 000.
- Back-pressure:
  - Hold out_ready low 5 cycles in DONE -> result, out_class and out_valid stable.
  - in_valid held high with different operands throughout -> not accepted, in_ready 0.
  - Release out_ready -> IDLE next edge, then new accept.
- Drop rst_n at cycle 10 of MUL -> all outputs at reset values immediately. After release, 0x3F800000 × 0x3F800000 -> 0x3F800000, class 011.
